cpu_gen2: RTL and testbench

- Second-generation accumulator CPU; replaces the multi-clock, fixed-phase 8-bit core.
- Runs on a single clock with a width-parametrised datapath and one FSM for control.
- Talks to memory through an external req/ack port, so memory may insert any number of wait states.
- Keeps the same 8-opcode ISA. Adds halt-resume via a go input.

---
 rtl/cpu_gen2.sv | 173 +++++++++++++++++
 tb/tb_cpu_gen2.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_gen2.sv
// Accumulator CPU: single clock, parametrised datapath, one control FSM (IDLE/FETCH/DECODE/EXEC/HALT).
// Latency: 3 cycles per instruction with zero-wait memory; HLT reaches HALT 2 cycles after its fetch starts.
// Backpressure: the memory port holds req/addr/we/wdata until ack, so each wait state stretches the stalled state by one cycle.
//
// Ports: clk, rst_ (async, active low); mem_req/mem_we/mem_addr/mem_wdata out and mem_rdata/mem_ack in form the
// memory port; go resumes from HALT; halt, load_ir, state and accum expose core status.
module cpu_gen2 #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              go,
    output logic              halt,
    output logic              load_ir,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] accum
);

    // The opcode sits in the top three bits and the operand in the bottom ADDR_W bits,
    // so the word has to be wide enough to hold both without overlap.
    generate
        if (DATA_W < ADDR_W + 3) begin : g_bad_width
            $error("cpu_gen2: DATA_W must be at least ADDR_W+3");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t              cur_state;
    state_t              nxt_state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [DATA_W-1:0]   ac;
    logic [DATA_W-1:0]   ac_nxt;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   ir_nxt;
    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic                zero;
    logic                unused_ir_bits;

    assign opcode         = ir[DATA_W-1 -: 3];
    assign operand        = ir[ADDR_W-1:0];
    assign zero           = (ac == '0);
    // Bits between opcode and operand carry no meaning.
    assign unused_ir_bits = ^ir;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cur_state <= S_IDLE;
            pc        <= '0;
            ac        <= '0;
            ir        <= '0;
        end else begin
            cur_state <= nxt_state;
            pc        <= pc_nxt;
            ac        <= ac_nxt;
            ir        <= ir_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        pc_nxt    = pc;
        ac_nxt    = ac;
        ir_nxt    = ir;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        load_ir   = 1'b0;

        case (cur_state)
            S_IDLE: nxt_state = S_FETCH;

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    load_ir   = 1'b1;
                    ir_nxt    = mem_rdata;
                    nxt_state = S_DECODE;
                end
            end

            S_DECODE: begin
                pc_nxt    = pc + 1'b1;
                nxt_state = (opcode == OP_HLT) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        mem_req  = 1'b1;
                        mem_addr = operand;
                        if (mem_ack) begin
                            case (opcode)
                                OP_ADD:  ac_nxt = ac + mem_rdata;
                                OP_AND:  ac_nxt = ac & mem_rdata;
                                OP_XOR:  ac_nxt = ac ^ mem_rdata;
                                default: ac_nxt = mem_rdata;
                            endcase
                            nxt_state = S_FETCH;
                        end
                    end
                    OP_STO: begin
                        mem_req  = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = operand;
                        if (mem_ack) begin
                            nxt_state = S_FETCH;
                        end
                    end
                    OP_JMP: begin
                        pc_nxt    = operand;
                        nxt_state = S_FETCH;
                    end
                    OP_SKZ: begin
                        if (zero) begin
                            pc_nxt = pc + 1'b1;
                        end
                        nxt_state = S_FETCH;
                    end
                    // HLT never reaches EXEC; recover by fetching.
                    default: nxt_state = S_FETCH;
                endcase
            end

            S_HALT: begin
                if (go) begin
                    nxt_state = S_FETCH;
                end
            end

            default: nxt_state = S_IDLE;
        endcase

        // Reset must kill an in-flight request without waiting for the state register.
        if (!rst_) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_addr = '0;
            load_ir  = 1'b0;
        end
    end

    assign mem_wdata = ac;
    assign halt      = (cur_state == S_HALT);
    assign state     = cur_state;
    assign accum     = ac;

endmodule

// File: tb/tb_cpu_gen2.sv
// Self-checking bench for cpu_gen2: directed programs on an 8/5 core and a 12/7 core, an ALU vector table,
// and random programs compared instruction-by-instruction with an instruction-level model.
// Memory models answer requests with a programmable or random number of wait states.
module tb_cpu_gen2;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int AW2 = 7;
    localparam int DW2 = 12;
    localparam int ST_IDLE  = 0;
    localparam int ST_FETCH = 1;
    localparam int ST_EXEC  = 3;
    localparam int ST_HALT  = 4;
    localparam int LIMIT    = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A (8-bit data, 5-bit address)
    logic           rst_a;
    logic           req_a, we_a, ack_a, go, halt_a, load_ir_a;
    logic [AW-1:0]  addr_a;
    logic [DW-1:0]  wdata_a, rdata_a, accum_a;
    logic [2:0]     state_a;

    // DUT B (12-bit data, 7-bit address)
    logic           rst_b;
    logic           req_b, we_b, ack_b, go_b, halt_b, load_ir_b;
    logic [AW2-1:0] addr_b;
    logic [DW2-1:0] wdata_b, rdata_b, accum_b;
    logic [2:0]     state_b;

    cpu_gen2 #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk(clk), .rst_(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ack(ack_a), .go(go),
        .halt(halt_a), .load_ir(load_ir_a), .state(state_a), .accum(accum_a)
    );

    cpu_gen2 #(.ADDR_W(AW2), .DATA_W(DW2)) dut_b (
        .clk(clk), .rst_(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ack(ack_b), .go(go_b),
        .halt(halt_b), .load_ir(load_ir_b), .state(state_b), .accum(accum_b)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- memory A, monitor and instruction-level model ----------------
    logic [DW-1:0] mem_a [32];
    int            wait_n = 0;
    bit            rand_wait = 0;
    bit            stray = 0;
    int            cnt_a = 0;
    int            cur_wait = 0;
    bit            fire_a = 0;
    logic          f_we;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;

    int            fetch_q[$];
    int            prev_st = ST_IDLE;
    bit            chk_stab = 0;
    int            exp_len = 1;
    int            run_len = 0;
    logic [AW-1:0] l_addr;
    logic          l_we;
    logic [DW-1:0] l_wdata;

    logic [DW-1:0] m_mem [32];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac;
    int            m_fetch = 0;
    bit            model_on = 0;

    // Executes one whole instruction at the ISA level each time the core starts a fetch.
    function automatic void model_step(input logic [AW-1:0] pc_seen, input logic [DW-1:0] ac_seen);
        logic [DW-1:0] word;
        logic [2:0]    op;
        logic [AW-1:0] opd;
        check("rnd_fetch_pc", pc_seen, m_pc);
        check("rnd_accum", ac_seen, m_ac);
        m_fetch++;
        if (m_fetch > LIMIT) return;
        word = m_mem[m_pc];
        op   = word[DW-1 -: 3];
        opd  = word[AW-1:0];
        m_pc = m_pc + 1'b1;
        case (op)
            3'd1: if (m_ac == 0) m_pc = m_pc + 1'b1;
            3'd2: m_ac = m_ac + m_mem[opd];
            3'd3: m_ac = m_ac & m_mem[opd];
            3'd4: m_ac = m_ac ^ m_mem[opd];
            3'd5: m_ac = m_mem[opd];
            3'd6: m_mem[opd] = m_ac;
            3'd7: m_pc = opd;
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_a) begin
            prev_st = ST_IDLE;
            run_len = 0;
        end else begin
            if (int'(state_a) == ST_FETCH && prev_st != ST_FETCH) begin
                fetch_q.push_back(int'(addr_a));
                if (model_on) model_step(addr_a, accum_a);
            end
            if (chk_stab) begin
                if ((int'(state_a) != prev_st || !req_a) && run_len > 0) begin
                    check("req_len", run_len, exp_len);
                    run_len = 0;
                end
                if (req_a) begin
                    if (run_len == 0) begin
                        l_addr  = addr_a;
                        l_we    = we_a;
                        l_wdata = wdata_a;
                    end else begin
                        check("stable_addr", addr_a, l_addr);
                        check("stable_we", we_a, l_we);
                        check("stable_wdata", wdata_a, l_wdata);
                    end
                    run_len++;
                end
            end
            prev_st = int'(state_a);
        end

        // Write committed one half-cycle after the completing edge.
        if (fire_a && rst_a && f_we) mem_a[f_addr] = f_wdata;
        fire_a  = 0;
        rdata_a = DW'($urandom);
        if (!rst_a) begin
            ack_a = 1'b0;
            cnt_a = 0;
        end else if (req_a) begin
            if (cnt_a == 0) cur_wait = rand_wait ? int'($urandom_range(0, 2)) : wait_n;
            if (cnt_a >= cur_wait) begin
                ack_a = 1'b1;
                if (!we_a) rdata_a = mem_a[addr_a];
                fire_a  = 1;
                f_we    = we_a;
                f_addr  = addr_a;
                f_wdata = wdata_a;
                cnt_a   = 0;
            end else begin
                ack_a = 1'b0;
                cnt_a++;
            end
        end else begin
            ack_a = stray;
            cnt_a = 0;
        end
    end

    // ---------------- memory B: zero-wait ----------------
    logic [DW2-1:0] mem_b [128];
    bit             fire_b = 0;
    logic           fb_we;
    logic [AW2-1:0] fb_addr;
    logic [DW2-1:0] fb_wdata;

    always @(negedge clk) begin
        if (fire_b && rst_b && fb_we) mem_b[fb_addr] = fb_wdata;
        fire_b  = 0;
        ack_b   = 1'b0;
        rdata_b = DW2'($urandom);
        if (rst_b && req_b) begin
            ack_b = 1'b1;
            if (!we_b) rdata_b = mem_b[addr_b];
            fire_b   = 1;
            fb_we    = we_b;
            fb_addr  = addr_b;
            fb_wdata = wdata_b;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] enc(input int op, input int opd);
        enc = DW'((op << 5) | opd);
    endfunction

    task automatic clear_mem_a();
        foreach (mem_a[i]) mem_a[i] = '0;
        fetch_q.delete();
    endtask

    // Releases reset, checks the first FETCH cycle, then counts cycles until HALT.
    task automatic run_to_halt(input int w, input int budget, output int n);
        wait_n   = w;
        exp_len  = w + 1;
        chk_stab = 1;
        @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        @(negedge clk);
        n = 1;
        #1;
        check("first_state_fetch", state_a, ST_FETCH);
        check("first_load_ir", load_ir_a, (w == 0));
        while (!halt_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halt_a, 1);
    endtask

    typedef struct {
        logic [7:0] init;
        int         op;
        logic [7:0] data;
        logic [7:0] exp;
    } alu_vec_t;

    alu_vec_t alu_tab [8];
    int       n;
    int       budget_left;
    int       mism;

    initial begin
        alu_tab[0] = '{8'hFF, 2, 8'h02, 8'h01};
        alu_tab[1] = '{8'h01, 3, 8'h0F, 8'h01};
        alu_tab[2] = '{8'h01, 4, 8'h01, 8'h00};
        alu_tab[3] = '{8'h5A, 5, 8'hC3, 8'hC3};
        alu_tab[4] = '{8'h80, 2, 8'h80, 8'h00};
        alu_tab[5] = '{8'hF0, 3, 8'h3C, 8'h30};
        alu_tab[6] = '{8'hAA, 4, 8'hFF, 8'h55};
        alu_tab[7] = '{8'h7F, 2, 8'h01, 8'h80};

        rst_a = 1'b1;
        rst_b = 1'b1;
        go    = 1'b0;
        go_b  = 1'b0;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("rst_state", state_a, ST_IDLE);
        check("rst_halt", halt_a, 0);
        check("rst_req", req_a, 0);
        check("rst_we", we_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_accum", accum_a, 0);
        check("rst_load_ir", load_ir_a, 0);
        check("rst_state_b", state_b, ST_IDLE);

        // Zero-wait program, then the same program with three wait states per transaction.
        for (int pass = 0; pass < 2; pass++) begin
            rst_a = 1'b0;
            clear_mem_a();
            mem_a[0]  = 8'hAA;
            mem_a[10] = 8'h0F;
            mem_a[1]  = 8'h4B;
            mem_a[11] = 8'h01;
            mem_a[2]  = 8'hCC;
            mem_a[3]  = 8'h00;
            run_to_halt(pass * 3, 80, n);
            check("prog_halt_cycle", n, (pass == 0) ? 12 : 33);
            @(negedge clk);
            check("prog_mem12", mem_a[12], 8'h10);
            check("prog_accum", accum_a, 8'h10);
            check("prog_fetches", fetch_q.size(), 4);
        end

        // ALU vector table: LDA init; OP data; STO 22; HLT.
        for (int i = 0; i < 8; i++) begin
            rst_a = 1'b0;
            clear_mem_a();
            mem_a[0]  = enc(5, 20);
            mem_a[1]  = enc(alu_tab[i].op, 21);
            mem_a[2]  = enc(6, 22);
            mem_a[3]  = enc(0, 0);
            mem_a[20] = alu_tab[i].init;
            mem_a[21] = alu_tab[i].data;
            mem_a[22] = 8'h99;
            run_to_halt(i % 3, 120, n);
            check("alu_cycles", n, 7 * (i % 3) + 12);
            @(negedge clk);
            check("alu_accum", accum_a, alu_tab[i].exp);
            check("alu_mem", mem_a[22], alu_tab[i].exp);
        end

        // JMP 31, SKZ at 31 with AC=0: PC wraps to 0, skip lands on 1 (HLT).
        rst_a = 1'b0;
        clear_mem_a();
        mem_a[0]  = 8'hFF;
        mem_a[31] = 8'h20;
        run_to_halt(0, 40, n);
        check("skz0_fetches", fetch_q.size(), 3);
        check("skz0_second", fetch_q[1], 31);
        check("skz0_third", fetch_q[2], 1);

        // Same with AC=1: skip not taken, next fetch from 0.
        rst_a = 1'b0;
        clear_mem_a();
        mem_a[0]  = enc(5, 20);
        mem_a[1]  = 8'hFF;
        mem_a[31] = 8'h20;
        mem_a[20] = 8'h01;
        wait_n = 0;
        exp_len = 1;
        @(negedge clk);
        rst_a = 1'b1;
        budget_left = 60;
        while (fetch_q.size() < 4 && budget_left > 0) begin
            @(negedge clk);
            budget_left--;
        end
        check("skz1_fetches", fetch_q.size() >= 4, 1);
        check("skz1_third", fetch_q[2], 31);
        check("skz1_fourth", fetch_q[3], 0);

        // Halt/resume with stray ack and go during FETCH.
        rst_a = 1'b0;
        clear_mem_a();
        mem_a[0]  = enc(5, 20);
        mem_a[1]  = enc(0, 0);
        mem_a[2]  = enc(2, 21);
        mem_a[3]  = enc(0, 0);
        mem_a[20] = 8'h11;
        mem_a[21] = 8'h22;
        run_to_halt(1, 60, n);
        check("hr_req_in_halt", req_a, 0);
        stray = 1;
        repeat (3) @(negedge clk);
        #1;
        check("hr_stray_state", state_a, ST_HALT);
        check("hr_stray_accum", accum_a, 8'h11);
        stray = 0;
        go = 1'b1;
        @(negedge clk);
        #1;
        check("hr_resume_state", state_a, ST_FETCH);
        check("hr_resume_addr", addr_a, 2);
        @(negedge clk);
        #1;
        check("hr_go_in_fetch", state_a, ST_FETCH);
        go = 1'b0;
        n = 0;
        while (!halt_a && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("hr_halt_again", halt_a, 1);
        check("hr_accum", accum_a, 8'h33);
        check("hr_fetch3", fetch_q[fetch_q.size() - 1], 3);

        // Reset in the middle of a stalled STO.
        rst_a = 1'b0;
        clear_mem_a();
        mem_a[0]  = enc(5, 20);
        mem_a[1]  = enc(6, 22);
        mem_a[20] = 8'h5A;
        mem_a[22] = 8'h77;
        wait_n  = 3;
        exp_len = 4;
        @(negedge clk);
        rst_a = 1'b1;
        budget_left = 60;
        while (!(int'(state_a) == ST_EXEC && we_a) && budget_left > 0) begin
            @(negedge clk);
            budget_left--;
        end
        check("mid_sto_reached", we_a, 1);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("mid_rst_req", req_a, 0);
        check("mid_rst_accum", accum_a, 0);
        check("mid_rst_state", state_a, ST_IDLE);
        check("mid_rst_we", we_a, 0);
        fetch_q.delete();
        @(negedge clk);
        rst_a = 1'b1;
        budget_left = 20;
        while (fetch_q.size() == 0 && budget_left > 0) begin
            @(negedge clk);
            budget_left--;
        end
        check("mid_restart_addr", (fetch_q.size() > 0) ? fetch_q[0] : -1, 0);
        check("mid_no_write", mem_a[22], 8'h77);
        rst_a = 1'b0;
        chk_stab = 0;

        // Wide variant: same program re-encoded for 12-bit words / 7-bit addresses.
        foreach (mem_b[i]) mem_b[i] = '0;
        mem_b[0]  = DW2'((5 << 9) | 10);
        mem_b[10] = 12'h00F;
        mem_b[1]  = DW2'((2 << 9) | 11);
        mem_b[11] = 12'h001;
        mem_b[2]  = DW2'((6 << 9) | 12);
        mem_b[3]  = 12'h000;
        @(negedge clk);
        rst_b = 1'b1;
        n = 0;
        while (!halt_b && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wide_halt_cycle", n, 12);
        @(negedge clk);
        check("wide_mem12", mem_b[12], 12'h010);
        check("wide_accum", accum_b, 12'h010);

        // Random programs with random wait states against the instruction-level model.
        for (int p = 0; p < 6; p++) begin
            rst_a = 1'b0;
            clear_mem_a();
            foreach (mem_a[i]) begin
                mem_a[i] = DW'($urandom);
                m_mem[i] = mem_a[i];
            end
            m_pc      = '0;
            m_ac      = '0;
            m_fetch   = 0;
            model_on  = 1;
            rand_wait = 1;
            @(negedge clk);
            rst_a = 1'b1;
            budget_left = 3000;
            while (m_fetch <= LIMIT && budget_left > 0) begin
                @(negedge clk);
                go = halt_a;
                budget_left--;
            end
            check("rnd_progress", m_fetch > LIMIT, 1);
            @(negedge clk);
            rst_a = 1'b0;
            go = 1'b0;
            model_on = 0;
            mism = 0;
            foreach (mem_a[i]) if (mem_a[i] !== m_mem[i]) mism++;
            check("rnd_memory", mism, 0);
        end
        rand_wait = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
